// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS ID stage: opcodes, functs, ALU ops and the
// layout of the ID/EX bundle handed to the execute stage.
package mips_pkg;

    localparam int ID_DATA_W = 62;
    localparam int EX_DATA_W = 150;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_LUI  = 4'd6;
    localparam logic [3:0] ALU_LINK = 4'd7;

    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_ALU_OP_LSB = 0;

    localparam int EX_CTRL_LSB = 141;
    localparam int EX_PCP1_LSB = 111;
    localparam int EX_RSD_LSB  = 79;
    localparam int EX_RTD_LSB  = 47;
    localparam int EX_IMM_LSB  = 15;
    localparam int EX_RS_LSB   = 10;
    localparam int EX_RT_LSB   = 5;
    localparam int EX_DST_LSB  = 0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [29:0] pcp1;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
    } ex_bundle_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of fetch, writeback, EX/MEM and execute-side signals seen by the ID stage.
interface id_stage_if;
    import mips_pkg::*;

    logic [ID_DATA_W-1:0] i_ID_DATA;
    logic                 wb_we;
    logic [4:0]           wb_addr;
    logic [31:0]          wb_data;
    logic                 mem_regWrite;
    logic                 mem_memRead;
    logic [4:0]           mem_dst;
    logic [31:0]          mem_aluRes;
    logic                 jpcAvail;
    logic [29:0]          JPC;
    logic                 IF_FLUSH;
    logic                 IF_CTRL;
    logic [EX_DATA_W-1:0] o_EX_DATA;

    modport slave (
        input  i_ID_DATA, wb_we, wb_addr, wb_data,
        input  mem_regWrite, mem_memRead, mem_dst, mem_aluRes,
        output jpcAvail, JPC, IF_FLUSH, IF_CTRL, o_EX_DATA
    );

    modport master (
        output i_ID_DATA, wb_we, wb_addr, wb_data,
        output mem_regWrite, mem_memRead, mem_dst, mem_aluRes,
        input  jpcAvail, JPC, IF_FLUSH, IF_CTRL, o_EX_DATA
    );
endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two combinational read ports with writeback bypass,
// one write port, $0 hardwired to zero.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (we && waddr != 5'd0) regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end

    always_comb begin
        if (raddr_a == 5'd0)                 rdata_a = '0;
        else if (we && waddr == raddr_a)     rdata_a = wdata;
        else                                 rdata_a = regs_q[raddr_a];
    end

    always_comb begin
        if (raddr_b == 5'd0)                 rdata_b = '0;
        else if (we && waddr == raddr_b)     rdata_b = wdata;
        else                                 rdata_b = regs_q[raddr_b];
    end
endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, register read, branch/jump resolution,
// load-use and branch-operand hazard detection, and the ID/EX pipeline register.
module id_stage
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    id_stage_if.slave bus
);
    logic [29:0] pcp1;
    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;

    assign pcp1   = bus.i_ID_DATA[61:32];
    assign instr  = bus.i_ID_DATA[31:0];
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    logic [31:0] rf_rs, rf_rt;

    regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.wb_we),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data),
        .raddr_a (rs),
        .rdata_a (rf_rs),
        .raddr_b (rt),
        .rdata_b (rf_rt)
    );

    ctrl_t       ctrl;
    logic [31:0] imm;
    logic [4:0]  dst;
    logic        uses_rs, uses_rt, is_beq, is_bne, is_jr, is_jump;

    always_comb begin
        ctrl    = '0;
        imm     = '0;
        dst     = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_jr   = 1'b0;
        is_jump = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
                dst            = rd;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADDU: ctrl.alu_op = ALU_ADD;
                    FN_SUBU: ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    FN_SLL: begin
                        ctrl.alu_op  = ALU_SLL;
                        ctrl.alu_src = 1'b1;
                        imm          = {27'b0, shamt};
                        uses_rs      = 1'b0;
                    end
                    FN_JR: begin
                        ctrl.reg_write = 1'b0;
                        dst            = '0;
                        uses_rt        = 1'b0;
                        is_jr          = 1'b1;
                    end
                    default: begin
                        ctrl.reg_write = 1'b0;
                        dst            = '0;
                        uses_rs        = 1'b0;
                        uses_rt        = 1'b0;
                    end
                endcase
            end
            OP_ADDIU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                imm            = sext16(imm16);
                dst            = rt;
                uses_rs        = 1'b1;
            end
            OP_ORI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_OR;
                imm            = {16'b0, imm16};
                dst            = rt;
                uses_rs        = 1'b1;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_LUI;
                imm            = {imm16, 16'b0};
                dst            = rt;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_ADD;
                imm             = sext16(imm16);
                dst             = rt;
                uses_rs         = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                imm            = sext16(imm16);
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                is_beq  = (opcode == OP_BEQ);
                is_bne  = (opcode == OP_BNE);
                imm     = sext16(imm16);
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_J: is_jump = 1'b1;
            OP_JAL: begin
                is_jump        = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_LINK;
                dst            = 5'd31;
            end
            default: ;
        endcase
        // all-zero word is the canonical nop, not "sll $0,$0,0"
        if (instr == '0) begin
            ctrl    = '0;
            imm     = '0;
            uses_rt = 1'b0;
        end
        if (dst == 5'd0) ctrl.reg_write = 1'b0;
    end

    ex_bundle_t  ex_q, ex_d;
    logic [31:0] br_rs, br_rt;
    logic [29:0] jpc;
    logic        is_brj, hit_ex, hit_mem, stall, taken;

    assign br_rs = (bus.mem_regWrite && !bus.mem_memRead && bus.mem_dst == rs && rs != 5'd0)
                   ? bus.mem_aluRes : rf_rs;
    assign br_rt = (bus.mem_regWrite && !bus.mem_memRead && bus.mem_dst == rt && rt != 5'd0)
                   ? bus.mem_aluRes : rf_rt;

    assign is_brj  = is_beq | is_bne | is_jr;
    assign hit_ex  = (ex_q.dst != 5'd0) &&
                     ((uses_rs && rs == ex_q.dst) || (uses_rt && rt == ex_q.dst));
    assign hit_mem = (bus.mem_dst != 5'd0) &&
                     ((uses_rs && rs == bus.mem_dst) || (uses_rt && rt == bus.mem_dst));

    // reset masks the hazard terms because ex_q is only cleared at the edge
    assign stall = !rst && ((ex_q.ctrl.mem_read && hit_ex) ||
                            (is_brj && ex_q.ctrl.reg_write && hit_ex) ||
                            (is_brj && bus.mem_memRead && hit_mem));
    assign taken = !rst && !stall &&
                   (is_jump || is_jr || (is_beq && br_rs == br_rt) || (is_bne && br_rs != br_rt));

    always_comb begin
        if (is_beq || is_bne) jpc = pcp1 + imm[29:0];
        else if (is_jr)       jpc = br_rs[31:2];
        else                  jpc = {pcp1[29:26], instr[25:0]};
    end

    always_comb begin
        ex_d = '0;
        if (!stall) begin
            ex_d.ctrl    = ctrl;
            ex_d.pcp1    = pcp1;
            ex_d.rs_data = rf_rs;
            ex_d.rt_data = rf_rt;
            ex_d.imm     = imm;
            ex_d.rs      = rs;
            ex_d.rt      = rt;
            ex_d.dst     = dst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    assign bus.jpcAvail  = taken;
    assign bus.JPC       = jpc;
    assign bus.IF_FLUSH  = taken;
    assign bus.IF_CTRL   = !stall;
    assign bus.o_EX_DATA = ex_q;
endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage with a cycle-tagged scoreboard: stimulus
// queues expected outputs, a negedge monitor pops and compares them.
module tb_id_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int           cyc;
        string        name;
        logic [149:0] mask;
        logic [149:0] val;
    } ex_exp_t;

    typedef struct {
        int          cyc;
        string       name;
        int          kind;
        logic [31:0] val;
    } cb_exp_t;

    ex_exp_t exq[$];
    cb_exp_t cbq[$];
    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [149:0] ONES = '1;
    localparam logic [149:0] M_ALL  = '1;
    localparam logic [149:0] M_CTRL = (ONES >> 141) << EX_CTRL_LSB;
    localparam logic [149:0] M_PCP1 = (ONES >> 120) << EX_PCP1_LSB;
    localparam logic [149:0] M_RSD  = (ONES >> 118) << EX_RSD_LSB;
    localparam logic [149:0] M_RTD  = (ONES >> 118) << EX_RTD_LSB;
    localparam logic [149:0] M_IMM  = (ONES >> 118) << EX_IMM_LSB;
    localparam logic [149:0] M_RS   = (ONES >> 145) << EX_RS_LSB;
    localparam logic [149:0] M_RT   = (ONES >> 145) << EX_RT_LSB;
    localparam logic [149:0] M_DST  = (ONES >> 145) << EX_DST_LSB;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [149:0] mk(input logic [8:0] c, input logic [29:0] p,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] i, input logic [4:0] s,
                                        input logic [4:0] t, input logic [4:0] d);
        return {c, p, a, b, i, s, t, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_in(input logic [29:0] pc, input logic [31:0] ins);
        bus.i_ID_DATA = {pc, ins};
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.wb_we = we; bus.wb_addr = a; bus.wb_data = d;
    endtask

    task automatic mem(input logic rw, input logic mr, input logic [4:0] d, input logic [31:0] r);
        bus.mem_regWrite = rw; bus.mem_memRead = mr; bus.mem_dst = d; bus.mem_aluRes = r;
    endtask

    task automatic exp_cb(input string nm, input logic ifc, input logic jav, input logic fl);
        cbq.push_back('{cyc, {nm, ".IF_CTRL"},  0, {31'b0, ifc}});
        cbq.push_back('{cyc, {nm, ".jpcAvail"}, 1, {31'b0, jav}});
        cbq.push_back('{cyc, {nm, ".IF_FLUSH"}, 3, {31'b0, fl}});
    endtask

    task automatic exp_jpc(input string nm, input logic [29:0] t);
        cbq.push_back('{cyc, nm, 2, {2'b0, t}});
    endtask

    task automatic exp_ex(input string nm, input logic [149:0] m, input logic [149:0] v);
        exq.push_back('{cyc + 1, nm, m, v});
    endtask

    cb_exp_t     ce;
    ex_exp_t     ee;
    logic [31:0] act;

    initial begin
        forever begin
            @(negedge clk);
            while (cbq.size() > 0 && cbq[0].cyc <= cyc) begin
                ce = cbq.pop_front();
                case (ce.kind)
                    0:       act = {31'b0, bus.IF_CTRL};
                    1:       act = {31'b0, bus.jpcAvail};
                    2:       act = {2'b0, bus.JPC};
                    default: act = {31'b0, bus.IF_FLUSH};
                endcase
                n_chk++;
                if (ce.cyc != cyc || act !== ce.val) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d): got %h, expected %h", ce.name, cyc, act, ce.val);
                end
            end
            while (exq.size() > 0 && exq[0].cyc <= cyc) begin
                ee = exq.pop_front();
                n_chk++;
                if (ee.cyc != cyc || (bus.o_EX_DATA & ee.mask) !== (ee.val & ee.mask)) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d): o_EX_DATA got %h, expected %h under mask %h",
                             ee.name, cyc, bus.o_EX_DATA & ee.mask, ee.val & ee.mask, ee.mask);
                end
            end
        end
    end

    initial begin
        bus.i_ID_DATA = '0;
        wb(1'b0, 5'd0, 32'd0);
        mem(1'b0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        tick();

        // reset with a jump in ID: no redirect, PC keeps running, ID/EX cleared
        id_in(30'h0, 32'h0800_0010);
        exp_cb("rst_hold0", 1'b1, 1'b0, 1'b0);
        exp_ex("rst_clear", M_ALL, '0);
        tick();
        exp_cb("rst_hold1", 1'b1, 1'b0, 1'b0);
        tick();

        rst = 1'b0;
        id_in(30'h1, 32'h2402_0005);                     // addiu $2,$0,5
        exp_cb("addiu", 1'b1, 1'b0, 1'b0);
        exp_ex("addiu_ex", M_ALL, mk(9'h110, 30'h1, 32'd0, 32'd0, 32'd5, 5'd0, 5'd2, 5'd2));
        tick();

        id_in(30'h0, 32'h0);
        wb(1'b1, 5'd1, 32'd7);
        tick();

        id_in(30'h10, 32'h1022_0004);                    // beq $1,$2,+4 ; $2 via bypass
        wb(1'b1, 5'd2, 32'd7);
        exp_cb("beq_taken", 1'b1, 1'b1, 1'b1);
        exp_jpc("beq_jpc", 30'h14);
        exp_ex("beq_nop", M_CTRL, '0);
        tick();

        wb(1'b0, 5'd0, 32'd0);
        id_in(30'h20, 32'h8C23_0000);                    // lw $3,0($1)
        exp_ex("lw_ex", M_ALL, mk(9'h1B0, 30'h20, 32'd7, 32'd0, 32'd0, 5'd1, 5'd3, 5'd3));
        tick();

        id_in(30'h21, 32'h0063_2021);                    // addu $4,$3,$3
        exp_cb("loaduse_stall", 1'b0, 1'b0, 1'b0);
        exp_ex("loaduse_bubble", M_ALL, '0);
        tick();
        exp_cb("loaduse_release", 1'b1, 1'b0, 1'b0);
        exp_ex("addu_issue", M_CTRL | M_PCP1 | M_RS | M_RT | M_DST,
               mk(9'h100, 30'h21, 32'd0, 32'd0, 32'd0, 5'd3, 5'd3, 5'd4));
        tick();

        id_in(30'h0, 32'h0);
        wb(1'b1, 5'd5, 32'd9);
        tick();

        wb(1'b0, 5'd0, 32'd0);
        id_in(30'h30, 32'h0022_2821);                    // addu $5,$1,$2
        exp_ex("addu5_ex", M_CTRL | M_DST, mk(9'h100, 30'h0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd5));
        tick();

        id_in(30'h31, 32'h14A0_0008);                    // bne $5,$0,+8
        exp_cb("bne_ex_stall", 1'b0, 1'b0, 1'b0);
        exp_ex("bne_bubble", M_ALL, '0);
        tick();
        mem(1'b1, 1'b0, 5'd5, 32'd0);
        exp_cb("bne_fwd_untaken", 1'b1, 1'b0, 1'b0);
        exp_ex("bne_nop", M_CTRL, '0);
        tick();

        mem(1'b0, 1'b1, 5'd1, 32'hDEAD_BEEF);            // MEM load to $1 stalls beq
        id_in(30'h10, 32'h1022_0004);
        exp_cb("beq_mem_load_stall", 1'b0, 1'b0, 1'b0);
        exp_ex("beq_mem_bubble", M_ALL, '0);
        tick();

        mem(1'b0, 1'b0, 5'd0, 32'd0);
        id_in(30'h0, 32'h0);
        wb(1'b1, 5'd31, 32'h400);
        tick();

        wb(1'b0, 5'd0, 32'd0);
        id_in(30'h0C00_0001, 32'h0C00_0100);             // jal 0x100
        exp_cb("jal_taken", 1'b1, 1'b1, 1'b1);
        exp_jpc("jal_jpc", 30'h0C00_0100);
        exp_ex("jal_ex", M_CTRL | M_PCP1 | M_DST,
               mk(9'h107, 30'h0C00_0001, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd31));
        tick();
        id_in(30'h0, 32'h0);
        tick();

        id_in(30'h40, 32'h03E0_0008);                    // jr $31
        exp_cb("jr_taken", 1'b1, 1'b1, 1'b1);
        exp_jpc("jr_jpc", 30'h100);
        exp_ex("jr_nop", M_CTRL, '0);
        tick();

        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        id_in(30'h50, 32'h0000_3021);                    // addu $6,$0,$0
        exp_ex("r0_bypass", M_CTRL | M_RSD | M_RTD | M_DST,
               mk(9'h100, 30'h0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd6));
        tick();
        wb(1'b0, 5'd0, 32'd0);
        exp_ex("r0_after_write", M_CTRL | M_RSD | M_RTD | M_DST,
               mk(9'h100, 30'h0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd6));
        tick();

        id_in(30'h60, 32'h3427_8001);                    // ori $7,$1,0x8001
        exp_ex("ori_ex", M_CTRL | M_RSD | M_IMM | M_DST,
               mk(9'h113, 30'h0, 32'd7, 32'd0, 32'h0000_8001, 5'd0, 5'd0, 5'd7));
        tick();

        id_in(30'h61, 32'h3C08_1234);                    // lui $8,0x1234
        exp_cb("lui_nostall", 1'b1, 1'b0, 1'b0);
        exp_ex("lui_ex", M_CTRL | M_IMM | M_DST,
               mk(9'h116, 30'h0, 32'd0, 32'd0, 32'h1234_0000, 5'd0, 5'd0, 5'd8));
        tick();

        id_in(30'h62, 32'hAC22_FFFC);                    // sw $2,-4($1)
        exp_ex("sw_ex", M_CTRL | M_RSD | M_RTD | M_IMM | M_DST,
               mk(9'h050, 30'h0, 32'd7, 32'd7, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd0));
        tick();

        id_in(30'h70, 32'h8C23_0000);                    // lw $3,0($1)
        tick();

        rst = 1'b1;                                      // reset during load-use stall
        id_in(30'h71, 32'h0063_2021);
        exp_cb("rst_mid_stall", 1'b1, 1'b0, 1'b0);
        exp_ex("rst_mid_stall_clear", M_ALL, '0);
        tick();

        rst = 1'b0;
        exp_cb("post_rst_issue", 1'b1, 1'b0, 1'b0);
        tick();

        id_in(30'h60, 32'h3427_8001);                    // $1 must read back as 0
        exp_ex("rf_cleared", M_CTRL | M_RSD,
               mk(9'h113, 30'h0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0));
        tick();

        id_in(30'h0, 32'h0);
        repeat (3) tick();

        n_chk++;
        if (cbq.size() != 0 || exq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", cbq.size() + exq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
